// File: rtl/seq_goto_checker.sv
// ---------------------------------------------------------------------------
// seq_goto_checker
//
// Hardware evaluation of the temporal check
//    a ##1 b[->N]   (goto repetition, mode = 0)
//    a ##1 b[*N]    (consecutive repetition, mode = 1)
// over a live a/b stream. Only one attempt is evaluated at a time; triggers
// that arrive while an attempt is running are dropped and counted.
//
// Parameters
//    GOTO_CNT : number of b hits required (1..15)
//    TIMEOUT  : WAIT edges allowed before a goto attempt fails (2..255)
//    CNT_W    : width of the saturating statistics counters
//
// Ports
//    i_clk      : rising-edge clock
//    i_rst      : asynchronous active-high reset
//    i_en       : check enable; low aborts any attempt silently
//    i_mode     : 0 = goto, 1 = consecutive; latched on the trigger edge
//    i_a        : antecedent / trigger
//    i_b        : repeated event
//    o_busy     : attempt in flight
//    o_pass     : one-cycle pulse on successful completion
//    o_fail     : one-cycle pulse on failed attempt
//    o_pass_cnt : saturating pass count
//    o_fail_cnt : saturating fail count
//    o_ign_cnt  : saturating count of triggers dropped while busy
// ---------------------------------------------------------------------------
module seq_goto_checker #(
    parameter int GOTO_CNT = 2,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_a,
    input  logic             i_b,
    output logic             o_busy,
    output logic             o_pass,
    output logic             o_fail,
    output logic [CNT_W-1:0] o_pass_cnt,
    output logic [CNT_W-1:0] o_fail_cnt,
    output logic [CNT_W-1:0] o_ign_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0]       HIT_LAST   = 4'(GOTO_CNT);
    localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t     r_state;
    logic [3:0] r_hit;
    logic [7:0] r_timer;
    logic       r_mode;
    logic       r_busy;
    logic       r_pass;
    logic       r_fail;
    logic [CNT_W-1:0] r_passCnt;
    logic [CNT_W-1:0] r_failCnt;
    logic [CNT_W-1:0] r_ignCnt;

    state_t     w_stateNext;
    logic [3:0] w_hitNext;
    logic [7:0] w_timerNext;
    logic       w_modeNext;
    logic       w_passNext;
    logic       w_failNext;
    logic       w_ignInc;
    logic [3:0] w_hitPlus;

    assign w_hitPlus = r_hit + 4'd1;

    // Next-state and pulse decode. A disabled checker forces IDLE and clears
    // the attempt bookkeeping without producing any pulse or counter update.
    // In goto mode a completing b wins over a timeout on the same edge
    // because completion is tested first. A trigger seen in WAIT is always
    // dropped, including on the edge where the attempt finishes.
    always_comb begin
        w_stateNext = r_state;
        w_hitNext   = r_hit;
        w_timerNext = r_timer;
        w_modeNext  = r_mode;
        w_passNext  = 1'b0;
        w_failNext  = 1'b0;
        w_ignInc    = 1'b0;

        if (!i_en) begin
            w_stateNext = IDLE;
            w_hitNext   = 4'd0;
            w_timerNext = 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_a) begin
                        w_stateNext = WAIT;
                        w_hitNext   = 4'd0;
                        w_timerNext = 8'd0;
                        w_modeNext  = i_mode;
                    end
                end
                WAIT: begin
                    w_ignInc = i_a;
                    if (!r_mode) begin
                        if (i_b && (w_hitPlus == HIT_LAST)) begin
                            w_passNext  = 1'b1;
                            w_stateNext = IDLE;
                            w_hitNext   = 4'd0;
                            w_timerNext = 8'd0;
                        end else if (r_timer == TIMER_LAST) begin
                            w_failNext  = 1'b1;
                            w_stateNext = IDLE;
                            w_hitNext   = 4'd0;
                            w_timerNext = 8'd0;
                        end else begin
                            w_timerNext = r_timer + 8'd1;
                            if (i_b) begin
                                w_hitNext = w_hitPlus;
                            end
                        end
                    end else begin
                        if (!i_b) begin
                            w_failNext  = 1'b1;
                            w_stateNext = IDLE;
                            w_hitNext   = 4'd0;
                        end else if (w_hitPlus == HIT_LAST) begin
                            w_passNext  = 1'b1;
                            w_stateNext = IDLE;
                            w_hitNext   = 4'd0;
                        end else begin
                            w_hitNext = w_hitPlus;
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // State, attempt bookkeeping and registered outputs. Busy is registered
    // from the next state so it tracks WAIT exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_hit   <= 4'd0;
            r_timer <= 8'd0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_hit   <= w_hitNext;
            r_timer <= w_timerNext;
            r_mode  <= w_modeNext;
            r_busy  <= (w_stateNext == WAIT);
            r_pass  <= w_passNext;
            r_fail  <= w_failNext;
        end
    end

    // Statistics counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_passCnt <= '0;
            r_failCnt <= '0;
            r_ignCnt  <= '0;
        end else begin
            if (w_passNext && (r_passCnt != CNT_MAX)) begin
                r_passCnt <= r_passCnt + CNT_ONE;
            end
            if (w_failNext && (r_failCnt != CNT_MAX)) begin
                r_failCnt <= r_failCnt + CNT_ONE;
            end
            if (w_ignInc && (r_ignCnt != CNT_MAX)) begin
                r_ignCnt <= r_ignCnt + CNT_ONE;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_pass_cnt = r_passCnt;
    assign o_fail_cnt = r_failCnt;
    assign o_ign_cnt  = r_ignCnt;

endmodule

// File: tb/tb_seq_goto_checker.sv
// ---------------------------------------------------------------------------
// tb_seq_goto_checker
//
// Directed bench for seq_goto_checker. The main instance uses the default
// parameters; a second instance with GOTO_CNT=1 and CNT_W=2 covers the
// single-hit case and counter saturation.
// ---------------------------------------------------------------------------
module tb_seq_goto_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       a;
    logic       b;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [7:0] passCnt;
    logic [7:0] failCnt;
    logic [7:0] ignCnt;

    logic       rst2;
    logic       en2;
    logic       mode2;
    logic       a2;
    logic       b2;
    logic       busy2;
    logic       pass2;
    logic       fail2;
    logic [1:0] passCnt2;
    logic [1:0] failCnt2;
    logic [1:0] ignCnt2;

    int checks;
    int errors;

    seq_goto_checker dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_mode     (mode),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_pass     (pass),
        .o_fail     (fail),
        .o_pass_cnt (passCnt),
        .o_fail_cnt (failCnt),
        .o_ign_cnt  (ignCnt)
    );

    seq_goto_checker #(
        .GOTO_CNT (1),
        .TIMEOUT  (16),
        .CNT_W    (2)
    ) dutSat (
        .i_clk      (clk),
        .i_rst      (rst2),
        .i_en       (en2),
        .i_mode     (mode2),
        .i_a        (a2),
        .i_b        (b2),
        .o_busy     (busy2),
        .o_pass     (pass2),
        .o_fail     (fail2),
        .o_pass_cnt (passCnt2),
        .o_fail_cnt (failCnt2),
        .o_ign_cnt  (ignCnt2)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the main instance's inputs, then advance one clock edge and
    // settle 1 unit past it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic vEn, input logic vMode,
                                 input logic vA, input logic vB);
        en   = vEn;
        mode = vMode;
        a    = vA;
        b    = vB;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1; en  = 1'b0; mode  = 1'b0; a  = 1'b0; b  = 1'b0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; a2 = 1'b0; b2 = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_pass", 32'(pass), 0);
        checkOutput("rst_fail", 32'(fail), 0);
        checkOutput("rst_passCnt", 32'(passCnt), 0);
        checkOutput("rst_failCnt", 32'(failCnt), 0);
        checkOutput("rst_ignCnt", 32'(ignCnt), 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        applyStimulus(1, 0, 0, 0);
        $display("[TB] reset released");

        // Goto pass: b at cycles 0 (ignored), 2 and 5
        applyStimulus(1, 0, 1, 1);
        checkOutput("t1_busy_c0", 32'(busy), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_busy_c1", 32'(busy), 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t1_busy_c2", 32'(busy), 1);
        checkOutput("t1_pass_c2", 32'(pass), 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_busy_c3", 32'(busy), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_busy_c4", 32'(busy), 1);
        checkOutput("t1_pass_c4", 32'(pass), 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t1_pass_c5", 32'(pass), 1);
        checkOutput("t1_busy_c5", 32'(busy), 0);
        checkOutput("t1_passCnt", 32'(passCnt), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_pass_drop", 32'(pass), 0);

        // Goto timeout: one b at cycle 3, fail on the 16th WAIT edge
        applyStimulus(1, 0, 1, 0);
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(1, 0, 0, (c == 3) ? 1'b1 : 1'b0);
            checkOutput("t2_busy_wait", 32'(busy), 1);
            checkOutput("t2_fail_wait", 32'(fail), 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_fail", 32'(fail), 1);
        checkOutput("t2_pass", 32'(pass), 0);
        checkOutput("t2_busy", 32'(busy), 0);
        checkOutput("t2_failCnt", 32'(failCnt), 1);
        checkOutput("t2_passCnt", 32'(passCnt), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_fail_drop", 32'(fail), 0);

        // Consecutive pass: b at cycles 1 and 2
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("t3_busy_c1", 32'(busy), 1);
        checkOutput("t3_pass_c1", 32'(pass), 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("t3_pass_c2", 32'(pass), 1);
        checkOutput("t3_passCnt", 32'(passCnt), 2);
        applyStimulus(1, 0, 0, 0);

        // Consecutive fail: b=1 then b=0; mode input flipped mid-attempt
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t3b_busy_c1", 32'(busy), 1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3b_fail", 32'(fail), 1);
        checkOutput("t3b_busy", 32'(busy), 0);
        checkOutput("t3b_failCnt", 32'(failCnt), 2);
        applyStimulus(1, 0, 0, 0);

        // Overlap: triggers at cycles 0..2, b at 1 and 2
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 1, 1);
        checkOutput("t4_ign_c1", 32'(ignCnt), 1);
        applyStimulus(1, 0, 1, 1);
        checkOutput("t4_pass", 32'(pass), 1);
        checkOutput("t4_ign_c2", 32'(ignCnt), 2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_busy_after", 32'(busy), 0);
        checkOutput("t4_pass_once", 32'(pass), 0);
        checkOutput("t4_passCnt", 32'(passCnt), 3);

        // Disable mid-attempt after one hit
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("t5_busy_dis", 32'(busy), 0);
        checkOutput("t5_pass_dis", 32'(pass), 0);
        checkOutput("t5_fail_dis", 32'(fail), 0);
        checkOutput("t5_ign_dis", 32'(ignCnt), 2);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t5_busy_idle", 32'(busy), 0);
        checkOutput("t5_passCnt_hold", 32'(passCnt), 3);
        checkOutput("t5_failCnt_hold", 32'(failCnt), 2);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t5_hit_cleared", 32'(pass), 0);
        checkOutput("t5_busy_c5", 32'(busy), 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t5_pass", 32'(pass), 1);
        checkOutput("t5_passCnt", 32'(passCnt), 4);

        // Async reset between edges while in WAIT
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t6_busy_pre", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_busy_rst", 32'(busy), 0);
        checkOutput("t6_passCnt_rst", 32'(passCnt), 0);
        checkOutput("t6_ignCnt_rst", 32'(ignCnt), 0);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 0, 1);
        checkOutput("t6_busy_post", 32'(busy), 0);
        checkOutput("t6_pass_post", 32'(pass), 0);
        en = 1'b0;

        // GOTO_CNT=1 and saturation on the CNT_W=2 instance
        en2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            a2 = 1'b1;
            b2 = 1'b1;
            applyStimulus(0, 0, 0, 0);
            checkOutput("t6s_busy_trig", 32'(busy2), 1);
            checkOutput("t6s_pass_trig", 32'(pass2), 0);
            a2 = 1'b0;
            b2 = 1'b1;
            applyStimulus(0, 0, 0, 0);
            checkOutput("t6s_pass", 32'(pass2), 1);
            checkOutput("t6s_passCnt", 32'(passCnt2), (k > 3) ? 3 : k);
        end
        b2 = 1'b0;
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6s_passCnt_sat", 32'(passCnt2), 3);
        checkOutput("t6s_failCnt", 32'(failCnt2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
